// File: rtl/alu_reg.sv
// rtl/alu_reg.sv - integer ALU with a one-cycle registered result stage
// Status flags are built only when ALU_FLAGS_EN is defined; otherwise flag_* are tied to 0.
module alu_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUControl,
   output logic [WIDTH-1:0] Result,
   output logic             out_valid,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_neg,
   output logic             flag_ovf
);
   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;

   logic [SHW-1:0]   w_sh;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] r_result;
   logic             r_valid;

   assign w_sh = B[SHW-1:0];

   always_comb begin
      w_result = '0;
      case (ALUControl)
         OP_ADD:  w_result = A + B;
         OP_SUB:  w_result = A - B;
         OP_AND:  w_result = A & B;
         OP_OR:   w_result = A | B;
         OP_XOR:  w_result = A ^ B;
         OP_SHL:  w_result = A << w_sh;
         OP_SHR:  w_result = A >> w_sh;
         default: w_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) r_result <= w_result;
      end
   end

   assign Result    = r_result;
   assign out_valid = r_valid;

`ifdef ALU_FLAGS_EN
   logic [SHW-1:0] w_shl_idx;
   logic [SHW-1:0] w_shr_idx;
   logic           w_carry;
   logic           w_ovf;
   logic           r_zero;
   logic           r_carry;
   logic           r_neg;
   logic           r_ovf;

   // Last bit shifted out: A[WIDTH-sh] for SHL, A[sh-1] for SHR; modulo-WIDTH index arithmetic.
   assign w_shl_idx = -w_sh;
   assign w_shr_idx = w_sh - SHW'(1);

   always_comb begin
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (ALUControl)
         OP_ADD: begin
            w_carry = (A[MSB] & B[MSB]) | ((A[MSB] | B[MSB]) & ~w_result[MSB]);
            w_ovf   = (A[MSB] == B[MSB]) && (w_result[MSB] != A[MSB]);
         end
         OP_SUB: begin
            w_carry = (A < B);
            w_ovf   = (A[MSB] != B[MSB]) && (w_result[MSB] != A[MSB]);
         end
         OP_SHL:  w_carry = (w_sh != '0) && A[w_shl_idx];
         OP_SHR:  w_carry = (w_sh != '0) && A[w_shr_idx];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
         r_neg   <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (in_valid) begin
         r_zero  <= (w_result == '0);
         r_carry <= w_carry;
         r_neg   <= w_result[MSB];
         r_ovf   <= w_ovf;
      end
   end

   assign flag_zero  = r_zero;
   assign flag_carry = r_carry;
   assign flag_neg   = r_neg;
   assign flag_ovf   = r_ovf;
`else
   assign flag_zero  = 1'b0;
   assign flag_carry = 1'b0;
   assign flag_neg   = 1'b0;
   assign flag_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_reg.sv
// tb/tb_alu_reg.sv - table-driven self-checking bench for alu_reg
// Flag expectations are masked to 0 unless ALU_FLAGS_EN is defined.
module tb_alu_reg;
`ifdef ALU_FLAGS_EN
   localparam bit FLAGS_EN = 1'b1;
`else
   localparam bit FLAGS_EN = 1'b0;
`endif
   localparam int NV = 18;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] a, b;
   logic [2:0] op;
   logic [7:0] result;
   logic       out_valid, f_zero, f_carry, f_neg, f_ovf;

   int n_total = 0;
   int n_pass  = 0;

   // flags packed as {zero, carry, neg, ovf}
   typedef struct {
      string      name;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] fl;
   } vec_t;

   vec_t vecs [NV];

   alu_reg #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .ALUControl(op),
      .Result(result), .out_valid(out_valid), .flag_zero(f_zero),
      .flag_carry(f_carry), .flag_neg(f_neg), .flag_ovf(f_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic check_out(input string nm, input logic [7:0] res, input logic vld,
                            input logic [3:0] fl);
      logic [3:0] exp_fl;
      exp_fl = FLAGS_EN ? fl : 4'b0000;
      check({nm, " result"}, {24'd0, result}, {24'd0, res});
      check({nm, " out_valid"}, {31'd0, out_valid}, {31'd0, vld});
      check({nm, " flags"}, {28'd0, f_zero, f_carry, f_neg, f_ovf}, {28'd0, exp_fl});
   endtask

   task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] xa,
                        input logic [7:0] xb);
      in_valid = v;
      op       = o;
      a        = xa;
      b        = xb;
   endtask

   initial begin
      vecs[0]  = '{"sweep_add",  3'b000, 8'h0F, 8'h03, 8'h12, 4'b0000};
      vecs[1]  = '{"sweep_sub",  3'b001, 8'h0F, 8'h03, 8'h0C, 4'b0000};
      vecs[2]  = '{"sweep_and",  3'b010, 8'h0F, 8'h03, 8'h03, 4'b0000};
      vecs[3]  = '{"sweep_or",   3'b011, 8'h0F, 8'h03, 8'h0F, 4'b0000};
      vecs[4]  = '{"sweep_xor",  3'b100, 8'h0F, 8'h03, 8'h0C, 4'b0000};
      vecs[5]  = '{"sweep_shl",  3'b101, 8'h0F, 8'h03, 8'h78, 4'b0000};
      vecs[6]  = '{"sweep_shr",  3'b110, 8'h0F, 8'h03, 8'h01, 4'b0100};
      vecs[7]  = '{"sweep_zero", 3'b111, 8'h0F, 8'h03, 8'h00, 4'b1000};
      vecs[8]  = '{"add_carry",  3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100};
      vecs[9]  = '{"add_ovf",    3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011};
      vecs[10] = '{"sub_borrow", 3'b001, 8'h03, 8'h0F, 8'hF4, 4'b0110};
      vecs[11] = '{"sub_ovf",    3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001};
      vecs[12] = '{"shl_out",    3'b101, 8'h81, 8'h01, 8'h02, 4'b0100};
      vecs[13] = '{"shr_wrap",   3'b110, 8'h81, 8'h09, 8'h40, 4'b0100};
      vecs[14] = '{"shl_zero",   3'b101, 8'h81, 8'h00, 8'h81, 4'b0010};
      vecs[15] = '{"shl_max",    3'b101, 8'h01, 8'h07, 8'h80, 4'b0010};
      vecs[16] = '{"shr_max",    3'b110, 8'h80, 8'h07, 8'h01, 4'b0000};
      vecs[17] = '{"and_zero",   3'b010, 8'hF0, 8'h0F, 8'h00, 4'b1000};

      // reset held two cycles with in_valid asserted
      rst = 1'b1;
      drive(1'b1, 3'b000, 8'hFF, 8'h01);
      repeat (2) @(negedge clk);
      check_out("reset", 8'h00, 1'b0, 4'b0000);
      rst = 1'b0;

      // back-to-back issue, one vector per cycle
      drive(1'b1, vecs[0].op, vecs[0].a, vecs[0].b);
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         check_out(vecs[i].name, vecs[i].res, 1'b1, vecs[i].fl);
         if (i + 1 < NV) drive(1'b1, vecs[i+1].op, vecs[i+1].a, vecs[i+1].b);
         else            drive(1'b0, 3'b000, 8'h00, 8'h00);
      end

      // hold: idle cycles keep Result and flags
      @(negedge clk);
      drive(1'b1, 3'b000, 8'h7F, 8'h01);
      @(negedge clk);
      check_out("hold_issue", 8'h80, 1'b1, 4'b0011);
      drive(1'b0, 3'b001, 8'h03, 8'h0F);
      @(negedge clk);
      check_out("hold_1", 8'h80, 1'b0, 4'b0011);
      drive(1'b0, 3'b111, 8'h55, 8'hAA);
      @(negedge clk);
      check_out("hold_2", 8'h80, 1'b0, 4'b0011);

      // reset wins over a valid operation in the same cycle
      drive(1'b1, 3'b001, 8'h03, 8'h0F);
      rst = 1'b1;
      @(negedge clk);
      check_out("mid_reset", 8'h00, 1'b0, 4'b0000);
      rst = 1'b0;
      drive(1'b1, 3'b011, 8'h0F, 8'h03);
      @(negedge clk);
      check_out("post_reset", 8'h0F, 1'b1, 4'b0000);
      drive(1'b0, 3'b000, 8'h00, 8'h00);
      @(negedge clk);
      check_out("post_idle", 8'h0F, 1'b0, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
